// File: rtl/control_resolve_unit_if.sv
// Purpose: bundles the control-queue head, CDB broadcast and front-end redirect
//          signals between control_queue/CDB arbiter (master) and control_resolve_unit (slave).
// Ports:   head_* from the queue head, dequeue back to it; cdb_* request/grant/payload; redirect/redirect_pc.
interface control_resolve_unit_if #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
);
  logic                     head_valid;
  logic                     head_pc_valid;
  logic [1:0]               head_op;
  logic [31:0]              head_pc_in;
  logic [31:0]              head_pc_new;
  logic                     head_br_en;
  logic [4:0]               head_rd;
  logic [PHYS_REG_BITS-1:0] head_pd;
  logic [ROB_IDX_BITS-1:0]  head_rob_idx;
  logic                     dequeue;

  logic                     cdb_req;
  logic                     cdb_gnt;
  logic                     cdb_rd_we;
  logic [4:0]               cdb_rd;
  logic [PHYS_REG_BITS-1:0] cdb_pd;
  logic [31:0]              cdb_value;
  logic [ROB_IDX_BITS-1:0]  cdb_rob_idx;

  logic                     redirect;
  logic [31:0]              redirect_pc;

  modport master (
    output head_valid, head_pc_valid, head_op, head_pc_in, head_pc_new, head_br_en,
           head_rd, head_pd, head_rob_idx, cdb_gnt,
    input  dequeue, cdb_req, cdb_rd_we, cdb_rd, cdb_pd, cdb_value, cdb_rob_idx,
           redirect, redirect_pc
  );

  modport slave (
    input  head_valid, head_pc_valid, head_op, head_pc_in, head_pc_new, head_br_en,
           head_rd, head_pd, head_rob_idx, cdb_gnt,
    output dequeue, cdb_req, cdb_rd_we, cdb_rd, cdb_pd, cdb_value, cdb_rob_idx,
           redirect, redirect_pc
  );
endinterface

// File: rtl/control_resolve_unit.sv
// Purpose: resolves the control-queue head (auipc/jal/jalr/branch), broadcasts on the CDB, pops the
//          queue and redirects the front end on a not-taken misprediction; saturating perf counters.
// Latency: head ready in cycle t -> cdb_req in t+1 -> dequeue/redirect in the cycle cdb_gnt is seen.
// Backpressure: cdb_* held stable until cdb_gnt; rob_flush aborts with no dequeue/redirect/count.
// Ports:   clk, rst_n (async active-low), rob_flush, cq (slave side of control_resolve_unit_if),
//          resolved_cnt / mispred_cnt perf counters.
module control_resolve_unit #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int CNT_BITS      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rob_flush,
  control_resolve_unit_if.slave cq,
  output logic [CNT_BITS-1:0]   resolved_cnt,
  output logic [CNT_BITS-1:0]   mispred_cnt
);

  localparam logic [1:0] OP_AUIPC  = 2'd0;
  localparam logic [1:0] OP_JAL    = 2'd1;
  localparam logic [1:0] OP_JALR   = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  typedef enum logic {IDLE, BCAST} state_t;

  state_t                   state_q, state_d;
  logic                     latch_en, fire;

  logic                     rd_we_q;
  logic [4:0]               rd_q;
  logic [PHYS_REG_BITS-1:0] pd_q;
  logic [31:0]              value_q;
  logic [ROB_IDX_BITS-1:0]  rob_idx_q;
  logic                     mispred_q;
  logic [31:0]              pc_new_q;

  logic [31:0]              pc_plus4;
  logic                     target_moved;
  logic [31:0]              value_d;
  logic                     mispred_d;
  logic                     rd_we_d;

  // Prediction is always fall-through, so any resolved target other than pc+4 is a mispredict.
  assign pc_plus4     = cq.head_pc_in + 32'd4;
  assign target_moved = (cq.head_pc_new != pc_plus4);

  always_comb begin
    value_d   = 32'd0;
    mispred_d = 1'b0;
    case (cq.head_op)
      OP_AUIPC:         value_d = cq.head_pc_new;
      OP_JAL, OP_JALR: begin
        value_d   = pc_plus4;
        mispred_d = target_moved;
      end
      OP_BRANCH:        mispred_d = cq.head_br_en & target_moved;
      default:          value_d = 32'd0;
    endcase
  end

  assign rd_we_d = (cq.head_op != OP_BRANCH) && (cq.head_rd != 5'd0);

  always_comb begin
    state_d    = state_q;
    latch_en   = 1'b0;
    fire       = 1'b0;
    cq.cdb_req = 1'b0;
    cq.dequeue = 1'b0;
    cq.redirect = 1'b0;
    case (state_q)
      IDLE: begin
        if (cq.head_valid && cq.head_pc_valid && !rob_flush) begin
          latch_en = 1'b1;
          state_d  = BCAST;
        end
      end
      BCAST: begin
        cq.cdb_req = 1'b1;
        // Flush beats a same-cycle grant: the op is abandoned, not completed.
        if (rob_flush) begin
          state_d = IDLE;
        end else if (cq.cdb_gnt) begin
          fire        = 1'b1;
          cq.dequeue  = 1'b1;
          cq.redirect = mispred_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_we_q   <= 1'b0;
      rd_q      <= 5'd0;
      pd_q      <= '0;
      value_q   <= 32'd0;
      rob_idx_q <= '0;
      mispred_q <= 1'b0;
      pc_new_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        rd_we_q   <= rd_we_d;
        rd_q      <= cq.head_rd;
        pd_q      <= cq.head_pd;
        value_q   <= value_d;
        rob_idx_q <= cq.head_rob_idx;
        mispred_q <= mispred_d;
        pc_new_q  <= cq.head_pc_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else if (fire) begin
      if (resolved_cnt != '1) resolved_cnt <= resolved_cnt + 1'b1;
      if (mispred_q && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign cq.cdb_rd_we   = rd_we_q;
  assign cq.cdb_rd      = rd_q;
  assign cq.cdb_pd      = pd_q;
  assign cq.cdb_value   = value_q;
  assign cq.cdb_rob_idx = rob_idx_q;
  assign cq.redirect_pc = pc_new_q;

endmodule

// File: tb/tb_control_resolve_unit.sv
module tb_control_resolve_unit;
  localparam int PRB = 6;
  localparam int RIB = 5;
  localparam int CB  = 3;
  localparam logic [CB-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rob_flush = 1'b0;
  logic [CB-1:0] resolved_cnt, mispred_cnt;

  control_resolve_unit_if #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB)) bus ();

  control_resolve_unit #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .CNT_BITS(CB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rob_flush    (rob_flush),
    .cq           (bus),
    .resolved_cnt (resolved_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    value;
    logic           rd_we;
    logic [4:0]     rd;
    logic [PRB-1:0] pd;
    logic [RIB-1:0] rob;
    logic           redir;
    logic [31:0]    rpc;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [CB-1:0] exp_res = '0;
  logic [CB-1:0] exp_mis = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every dequeue and checks the CDB payload held while waiting.
  logic [48:0] prev_snap;
  logic        have_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && bus.cdb_req)
          chk("cdb_stable", {bus.cdb_value, bus.cdb_rd_we, bus.cdb_rd, bus.cdb_pd, bus.cdb_rob_idx}, prev_snap);
        if (bus.dequeue) begin
          if (expq.size() == 0) begin
            chk("unexpected_dequeue", 1, 0);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("deq_cdb_req", bus.cdb_req, 1);
            chk("cdb_value", bus.cdb_value, e.value);
            chk("cdb_rd_we", bus.cdb_rd_we, e.rd_we);
            chk("cdb_rd", bus.cdb_rd, e.rd);
            chk("cdb_pd", bus.cdb_pd, e.pd);
            chk("cdb_rob_idx", bus.cdb_rob_idx, e.rob);
            chk("redirect", bus.redirect, e.redir);
            if (e.redir) chk("redirect_pc", bus.redirect_pc, e.rpc);
          end
        end else if (bus.redirect) begin
          chk("stray_redirect", 1, 0);
        end
        prev_snap = {bus.cdb_value, bus.cdb_rd_we, bus.cdb_rd, bus.cdb_pd, bus.cdb_rob_idx};
        have_prev = bus.cdb_req && !bus.dequeue && !rob_flush;
      end
    end
  end

  function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + 1'b1 : v;
  endfunction

  task automatic idle_head();
    bus.head_valid    = 1'b0;
    bus.head_pc_valid = 1'b0;
    bus.head_op       = 2'd0;
    bus.head_pc_in    = 32'd0;
    bus.head_pc_new   = 32'd0;
    bus.head_br_en    = 1'b0;
    bus.head_rd       = 5'd0;
    bus.head_pd       = '0;
    bus.head_rob_idx  = '0;
  endtask

  task automatic drive_head(input logic [1:0] op, input logic [31:0] pc_in, input logic [31:0] pc_new,
                            input logic br_en, input logic [4:0] rd, input logic [PRB-1:0] pd,
                            input logic [RIB-1:0] rob, input logic pcv);
    bus.head_valid    = 1'b1;
    bus.head_pc_valid = pcv;
    bus.head_op       = op;
    bus.head_pc_in    = pc_in;
    bus.head_pc_new   = pc_new;
    bus.head_br_en    = br_en;
    bus.head_rd       = rd;
    bus.head_pd       = pd;
    bus.head_rob_idx  = rob;
  endtask

  // One op: exp_value/exp_we/exp_red are hand-computed by the caller.
  task automatic do_op(input logic [1:0] op, input logic [31:0] pc_in, input logic [31:0] pc_new,
                       input logic br_en, input logic [4:0] rd, input logic [PRB-1:0] pd,
                       input logic [RIB-1:0] rob, input logic [31:0] exp_value, input logic exp_we,
                       input logic exp_red, input int pre_wait, input int gnt_delay);
    exp_t e;
    e.value = exp_value; e.rd_we = exp_we; e.rd = rd; e.pd = pd; e.rob = rob;
    e.redir = exp_red;   e.rpc = pc_new;
    expq.push_back(e);
    @(posedge clk); #1;
    drive_head(op, pc_in, pc_new, br_en, rd, pd, rob, 1'b0);
    for (int i = 0; i < pre_wait; i++) begin
      @(negedge clk);
      chk("no_req_before_pc_valid", bus.cdb_req, 0);
      @(posedge clk); #1;
    end
    bus.head_pc_valid = 1'b1;
    @(negedge clk);
    chk("req_low_in_ready_cycle", bus.cdb_req, 0);
    @(posedge clk); #1;
    // Head changes while broadcasting must not leak into the CDB payload.
    drive_head(op + 2'd1, ~pc_in, ~pc_new, ~br_en, rd ^ 5'h1f, ~pd, ~rob, 1'b1);
    for (int i = 0; i <= gnt_delay; i++) begin
      bus.cdb_gnt = (i == gnt_delay);
      @(negedge clk);
      chk("req_in_bcast", bus.cdb_req, 1);
      if (i < gnt_delay) chk("no_early_dequeue", bus.dequeue, 0);
      @(posedge clk); #1;
    end
    bus.cdb_gnt = 1'b0;
    idle_head();
    exp_res = sat_inc(exp_res, 1'b1);
    exp_mis = sat_inc(exp_mis, exp_red);
    chk("resolved_cnt", resolved_cnt, exp_res);
    chk("mispred_cnt", mispred_cnt, exp_mis);
    @(negedge clk);
    chk("req_drop_after_gnt", bus.cdb_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_head();
    bus.cdb_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cdb_req", bus.cdb_req, 0);
    chk("rst_dequeue", bus.dequeue, 0);
    chk("rst_redirect", bus.redirect, 0);
    chk("rst_cdb_value", bus.cdb_value, 0);
    chk("rst_resolved_cnt", resolved_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    rst_n = 1'b1;

    // op, pc_in, pc_new, br_en, rd, pd, rob, value, rd_we, redirect, pre_wait, gnt_delay
    do_op(2'd1, 32'h1000, 32'h2000, 1'b0, 5'd1, 6'd9,  5'd2, 32'h1004, 1'b1, 1'b1, 0, 0);
    do_op(2'd3, 32'h40,   32'h80,   1'b0, 5'd7, 6'd4,  5'd3, 32'h0,    1'b0, 1'b0, 0, 0);
    do_op(2'd3, 32'h40,   32'h80,   1'b1, 5'd7, 6'd5,  5'd4, 32'h0,    1'b0, 1'b1, 0, 1);
    do_op(2'd2, 32'h100,  32'h104,  1'b0, 5'd5, 6'd12, 5'd5, 32'h104,  1'b1, 1'b0, 0, 0);
    do_op(2'd0, 32'h300,  32'h5000, 1'b0, 5'd3, 6'd20, 5'd6, 32'h5000, 1'b1, 1'b0, 0, 0);
    do_op(2'd1, 32'h2000, 32'h2004, 1'b0, 5'd0, 6'd33, 5'd7, 32'h2004, 1'b0, 1'b0, 4, 3);

    // Flush arriving with the grant: nothing completes, unit returns to IDLE.
    @(posedge clk); #1;
    drive_head(2'd1, 32'h500, 32'h900, 1'b0, 5'd2, 6'd2, 5'd8, 1'b1);
    @(posedge clk); #1;
    rob_flush = 1'b1;
    bus.cdb_gnt = 1'b1;
    @(negedge clk);
    chk("flush_gnt_dequeue", bus.dequeue, 0);
    chk("flush_gnt_redirect", bus.redirect, 0);
    @(posedge clk); #1;
    rob_flush = 1'b0;
    bus.cdb_gnt = 1'b0;
    idle_head();
    @(negedge clk);
    chk("flush_gnt_req_dropped", bus.cdb_req, 0);
    chk("flush_resolved_cnt", resolved_cnt, exp_res);
    chk("flush_mispred_cnt", mispred_cnt, exp_mis);

    // Flush while a ready head sits in IDLE: no latch.
    @(posedge clk); #1;
    drive_head(2'd1, 32'h600, 32'hA00, 1'b0, 5'd2, 6'd2, 5'd8, 1'b1);
    rob_flush = 1'b1;
    @(posedge clk); #1;
    rob_flush = 1'b0;
    idle_head();
    @(negedge clk);
    chk("flush_idle_no_latch", bus.cdb_req, 0);

    // pc+4 wraps to 0, matching target -> no mispredict.
    do_op(2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 5'd4, 6'd1, 5'd9, 32'h0, 1'b1, 1'b0, 0, 0);

    // Drive both counters into saturation.
    for (int i = 0; i < 6; i++)
      do_op(2'd1, 32'h10 * i, 32'h8000, 1'b0, 5'd6, 6'd10, 5'd10, 32'h10 * i + 32'd4, 1'b1, 1'b1, 0, 0);

    // Async reset between edges while broadcasting.
    @(posedge clk); #1;
    drive_head(2'd1, 32'h700, 32'h800, 1'b0, 5'd8, 6'd11, 5'd12, 1'b1);
    @(posedge clk); #1;
    idle_head();
    @(negedge clk);
    chk("pre_reset_req", bus.cdb_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cdb_req", bus.cdb_req, 0);
    chk("async_rst_cdb_value", bus.cdb_value, 0);
    chk("async_rst_cdb_pd", bus.cdb_pd, 0);
    chk("async_rst_redirect_pc", bus.redirect_pc, 0);
    chk("async_rst_resolved_cnt", resolved_cnt, 0);
    chk("async_rst_mispred_cnt", mispred_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_res = '0;
    exp_mis = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
